// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives one outstanding imem request, applies irq/eret/jmp/branch redirects.
// Ack accepted the same cycle as the request; stall holds new requests off only once the current one is acked.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        irq,
    input  logic        eret,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic        in_isr
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] epc_q, epc_d;
    logic        in_isr_q, in_isr_d;
    logic        req_q, req_d;

    logic        irq_take;
    logic        redir;
    logic [31:0] redir_pc;

    always_comb begin
        irq_take = irq && !in_isr_q;
        redir    = irq_take || eret || jmp || br_taken;
        if (irq_take)
            redir_pc = IRQ_VEC;
        else if (eret)
            redir_pc = epc_q;
        else if (jmp)
            redir_pc = jmp_target;
        else
            redir_pc = br_target;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        epc_d    = epc_q;
        in_isr_d = in_isr_q;

        // Redirects update the architectural pc in every state except BOOT.
        if (state_q != BOOT && redir) begin
            pc_d = redir_pc;
            if (irq_take) begin
                epc_d    = pc_q;
                in_isr_d = 1'b1;
            end else if (eret) begin
                in_isr_d = 1'b0;
            end
        end

        case (state_q)
            BOOT: begin
                state_d = stall ? STALL : FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (!redir)
                        pc_d = pc_q + 32'd1;
                    state_d = stall ? STALL : FETCH;
                end else if (redir) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (imem_ack)
                    state_d = stall ? STALL : FETCH;
            end
            STALL: begin
                if (!stall)
                    state_d = FETCH;
            end
            default: state_d = BOOT;
        endcase

        // A new request starts whenever FETCH is (re)entered; an outstanding one keeps its address.
        if (state_d == FETCH && (state_q != FETCH || imem_ack))
            addr_d = pc_d;

        req_d = (state_d == FETCH) || (state_d == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            epc_q    <= 32'd0;
            in_isr_q <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            epc_q    <= epc_d;
            in_isr_q <= in_isr_d;
            req_q    <= req_d;
        end
    end

    assign imem_req    = req_q && !clr;
    assign imem_addr   = addr_q;
    assign instr_pc    = addr_q;
    assign instr_valid = (state_q == FETCH) && imem_ack && !redir && !clr;
    assign pc_out      = pc_q;
    assign epc_out     = epc_q;
    assign in_isr      = in_isr_q;

endmodule
